// File: rtl/clock_pkg.sv
// Shared encodings for the clock setting controller and the display driver.
// Mode and position values are fixed by the driver, so they are spelled out
// explicitly rather than left to enum auto-numbering.
package clock_pkg;

    // Operating mode of the clock; value 3 is never produced
    typedef enum logic [1:0] {
        MODE_CLOCK   = 2'd0,
        MODE_SETTING = 2'd1,
        MODE_ALARM   = 2'd2
    } mode_t;

    // Digit pair currently selected for editing
    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_t;

    // Button indices inside the packed button vector
    localparam int BTN_MODE  = 0;
    localparam int BTN_POS   = 1;
    localparam int BTN_INC   = 2;
    localparam int BTN_ALARM = 3;
    localparam int BTN_COUNT = 4;

    // Counter width able to hold 0 .. n-1; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Mode sequence CLOCK -> SETTING -> ALARM -> CLOCK; anything else recovers to CLOCK
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_CLOCK:   return MODE_SETTING;
            MODE_SETTING: return MODE_ALARM;
            default:      return MODE_CLOCK;
        endcase
    endfunction

    // Position sequence sec -> min -> hour -> sec; an illegal code restarts at sec
    function automatic pos_t next_pos(input pos_t p);
        case (p)
            POS_SEC: return POS_MIN;
            POS_MIN: return POS_HOUR;
            default: return POS_SEC;
        endcase
    endfunction

    // True in the two modes where digits are being edited
    function automatic logic is_edit_mode(input mode_t m);
        return (m == MODE_SETTING) || (m == MODE_ALARM);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: two-flop synchronizer, level debounce and a single-cycle
// pulse on every accepted 0->1 transition. The accepted level only moves
// after DEBOUNCE_CYC consecutive synchronized samples disagree with it, so a
// shorter glitch leaves no trace. Latency from a clean raw edge to the pulse
// is 2 (sync) + DEBOUNCE_CYC (qualification) + 1 (edge detect) cycles.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          level_d_reg;
    logic [CW-1:0] cnt_reg;

    // Two-flop synchronizer for the asynchronous raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive samples that differ from the accepted level; accept on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            level_reg <= sync2_reg;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Registered rising-edge detect on the accepted level; release produces nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_reg <= 1'b0;
            pulse       <= 1'b0;
        end else begin
            level_d_reg <= level_reg;
            pulse       <= level_reg & ~level_d_reg;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel controller for a digital clock: four debounced buttons drive
// the mode / edit-position state machine, increment strobes for the time
// counters, a blink phase for the digit being edited, an idle timeout that
// falls back to the running clock, and the alarm enable toggle.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 500000,
    parameter int BLINK_HALF_CYC   = 25000000,
    parameter int IDLE_TIMEOUT_CYC = 500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic       i_sw3,
    output logic [1:0] o_setting_mode,
    output logic [1:0] o_setting_position,
    output logic       o_blink,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_inc_hour,
    output logic       o_alarm_en
);

    localparam int            BW         = cnt_width(BLINK_HALF_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYC - 1);
    localparam int            IW         = cnt_width(IDLE_TIMEOUT_CYC);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT_CYC - 1);

    logic [BTN_COUNT-1:0] sw_raw;
    logic [BTN_COUNT-1:0] press;

    mode_t         mode_reg;
    pos_t          pos_reg;
    logic          blink_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic [IW-1:0] idle_cnt_reg;
    logic          inc_sec_reg;
    logic          inc_min_reg;
    logic          inc_hour_reg;
    logic          alarm_en_reg;

    logic in_edit;
    logic mode_press;
    logic pos_press;
    logic inc_press;
    logic edit_press;
    logic any_press;
    logic timeout;

    assign sw_raw = {i_sw3, i_sw2, i_sw1, i_sw0};

    // One debouncer per button, each producing a single-cycle press pulse
    generate
        for (genvar gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_btn_debounce (
                .clk  (clk),
                .rst_n(rst_n),
                .btn  (sw_raw[gi]),
                .pulse(press[gi])
            );
        end
    endgenerate

    // Press qualification: mode beats position beats increment in the same
    // cycle; position and increment only count while editing. The alarm
    // button stands apart from this priority chain.
    assign in_edit    = is_edit_mode(mode_reg);
    assign mode_press = press[BTN_MODE];
    assign pos_press  = in_edit & press[BTN_POS] & ~mode_press;
    assign inc_press  = in_edit & press[BTN_INC] & ~mode_press & ~press[BTN_POS];
    assign edit_press = mode_press | pos_press | inc_press;
    assign any_press  = |press;

    // A press arriving on the final idle cycle wins and restarts the idle count
    assign timeout = in_edit & ~any_press & (idle_cnt_reg == IDLE_LAST);

    // Mode / position state machine; every mode change restarts at the seconds digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg <= MODE_CLOCK;
            pos_reg  <= POS_SEC;
        end else if (mode_press) begin
            mode_reg <= next_mode(mode_reg);
            pos_reg  <= POS_SEC;
        end else if (timeout || !in_edit) begin
            // idle fallback, plain clock display, or recovery from an illegal code
            mode_reg <= MODE_CLOCK;
            pos_reg  <= POS_SEC;
        end else if (pos_press) begin
            pos_reg <= next_pos(pos_reg);
        end
    end

    // Increment strobes: exactly one, for one cycle, chosen by the current position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_sec_reg  <= 1'b0;
            inc_min_reg  <= 1'b0;
            inc_hour_reg <= 1'b0;
        end else begin
            inc_sec_reg  <= inc_press && (pos_reg == POS_SEC);
            inc_min_reg  <= inc_press && (pos_reg == POS_MIN);
            inc_hour_reg <= inc_press && (pos_reg == POS_HOUR);
        end
    end

    // Alarm enable flips on every alarm-button press regardless of mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_en_reg <= 1'b0;
        end else if (press[BTN_ALARM]) begin
            alarm_en_reg <= ~alarm_en_reg;
        end
    end

    // Blink phase while editing; any edit press restarts it in the visible phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
        end else if (!in_edit || edit_press || timeout) begin
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            blink_reg     <= ~blink_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    // Idle counter: runs only while editing and restarts on any button activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
        end else if (!in_edit || any_press || timeout) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end

    assign o_setting_mode     = mode_reg;
    assign o_setting_position = pos_reg;
    assign o_blink            = blink_reg;
    assign o_inc_sec          = inc_sec_reg;
    assign o_inc_min          = inc_min_reg;
    assign o_inc_hour         = inc_hour_reg;
    assign o_alarm_en         = alarm_en_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce, blink and idle
// periods. Inputs change on the falling edge and outputs are sampled there.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw0, sw1, sw2, sw3;
    logic [1:0] mode, pos;
    logic       blink, inc_sec, inc_min, inc_hour, alarm_en;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .DEBOUNCE_CYC    (4),
        .BLINK_HALF_CYC  (8),
        .IDLE_TIMEOUT_CYC(100)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_sw0             (sw0),
        .i_sw1             (sw1),
        .i_sw2             (sw2),
        .i_sw3             (sw3),
        .o_setting_mode    (mode),
        .o_setting_position(pos),
        .o_blink           (blink),
        .o_inc_sec         (inc_sec),
        .o_inc_min         (inc_min),
        .o_inc_hour        (inc_hour),
        .o_alarm_en        (alarm_en)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sw(input logic [3:0] m);
        sw0 = m[0];
        sw1 = m[1];
        sw2 = m[2];
        sw3 = m[3];
    endtask

    // Clean press: hold well past debounce, release, let release settle
    task automatic press(input logic [3:0] m);
        set_sw(m);
        tick(10);
        set_sw(4'b0000);
        tick(10);
    endtask

    task automatic test_reset;
        checks++; if (mode !== 2'd0)    begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        checks++; if (pos !== 2'd0)     begin failures++; $display("FAIL reset_pos got=%0d exp=0", pos); end
        checks++; if (blink !== 1'b0)   begin failures++; $display("FAIL reset_blink got=%0b exp=0", blink); end
        checks++; if ({inc_hour, inc_min, inc_sec} !== 3'b000)
            begin failures++; $display("FAIL reset_inc got=%b exp=000", {inc_hour, inc_min, inc_sec}); end
        checks++; if (alarm_en !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%0b exp=0", alarm_en); end
        rst_n = 1'b1;
        tick(3);
        checks++; if (mode !== 2'd0)    begin failures++; $display("FAIL post_reset_mode got=%0d exp=0", mode); end
        $display("reset: mode=%0d pos=%0d blink=%0b alarm=%0b", mode, pos, blink, alarm_en);
    endtask

    task automatic test_mode_cycle;
        logic [1:0] exp_mode;
        logic [1:0] old_mode;
        for (int i = 0; i < 3; i++) begin
            old_mode = 2'(i);
            exp_mode = 2'((i + 1) % 3);
            set_sw(4'b0001);
            tick(7);
            checks++; if (mode !== old_mode)
                begin failures++; $display("FAIL mode_early[%0d] got=%0d exp=%0d", i, mode, old_mode); end
            tick(1);
            checks++; if (mode !== exp_mode)
                begin failures++; $display("FAIL mode_step[%0d] got=%0d exp=%0d", i, mode, exp_mode); end
            checks++; if (pos !== 2'd0)
                begin failures++; $display("FAIL mode_pos[%0d] got=%0d exp=0", i, pos); end
            tick(2);
            set_sw(4'b0000);
            tick(10);
            $display("sw0 press %0d: mode=%0d pos=%0d", i, mode, pos);
        end
    endtask

    task automatic test_glitch;
        set_sw(4'b0001);
        tick(3);
        set_sw(4'b0000);
        tick(15);
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL glitch_mode got=%0d exp=0", mode); end
        $display("sw0 glitch 3 cycles: mode=%0d", mode);
    endtask

    task automatic test_clock_ignores;
        int inc_seen;
        inc_seen = 0;
        set_sw(4'b0110);
        for (int t = 0; t < 20; t++) begin
            tick(1);
            if (t == 10) set_sw(4'b0000);
            if (inc_sec || inc_min || inc_hour) inc_seen++;
        end
        checks++; if (pos !== 2'd0)   begin failures++; $display("FAIL clock_pos got=%0d exp=0", pos); end
        checks++; if (inc_seen !== 0) begin failures++; $display("FAIL clock_inc got=%0d exp=0", inc_seen); end
        $display("sw1+sw2 in CLOCK: pos=%0d inc_cycles=%0d", pos, inc_seen);
    endtask

    task automatic test_position_inc;
        logic [1:0] exp_pos;
        press(4'b0001);
        checks++; if (mode !== 2'd1) begin failures++; $display("FAIL enter_setting got=%0d exp=1", mode); end
        for (int i = 0; i < 3; i++) begin
            exp_pos = 2'((i + 1) % 3);
            press(4'b0010);
            checks++; if (pos !== exp_pos)
                begin failures++; $display("FAIL pos_step[%0d] got=%0d exp=%0d", i, pos, exp_pos); end
            $display("sw1 press %0d: pos=%0d", i, pos);
        end
        press(4'b0010);
        press(4'b0010);
        checks++; if (pos !== 2'd2) begin failures++; $display("FAIL pos_hour got=%0d exp=2", pos); end
        set_sw(4'b0100);
        tick(7);
        checks++; if ({inc_hour, inc_min, inc_sec} !== 3'b000)
            begin failures++; $display("FAIL inc_early got=%b exp=000", {inc_hour, inc_min, inc_sec}); end
        tick(1);
        checks++; if ({inc_hour, inc_min, inc_sec} !== 3'b100)
            begin failures++; $display("FAIL inc_hour got=%b exp=100", {inc_hour, inc_min, inc_sec}); end
        tick(1);
        checks++; if ({inc_hour, inc_min, inc_sec} !== 3'b000)
            begin failures++; $display("FAIL inc_width got=%b exp=000", {inc_hour, inc_min, inc_sec}); end
        set_sw(4'b0000);
        tick(10);
        checks++; if (pos !== 2'd2) begin failures++; $display("FAIL inc_pos got=%0d exp=2", pos); end
        $display("sw2 press at hour: strobe seen, pos=%0d", pos);
    endtask

    task automatic test_priority;
        press(4'b0010);
        press(4'b0010);
        checks++; if (pos !== 2'd1) begin failures++; $display("FAIL prio_setup_pos got=%0d exp=1", pos); end
        press(4'b0011);
        checks++; if (mode !== 2'd2) begin failures++; $display("FAIL prio_mode got=%0d exp=2", mode); end
        checks++; if (pos !== 2'd0)  begin failures++; $display("FAIL prio_pos got=%0d exp=0", pos); end
        $display("sw0+sw1 same cycle: mode=%0d pos=%0d", mode, pos);
        press(4'b1000);
        checks++; if (alarm_en !== 1'b1) begin failures++; $display("FAIL alarm_toggle got=%0b exp=1", alarm_en); end
        checks++; if (mode !== 2'd2)     begin failures++; $display("FAIL alarm_mode got=%0d exp=2", mode); end
        $display("sw3 press: alarm_en=%0b mode=%0d", alarm_en, mode);
    endtask

    task automatic test_reset_mid;
        press(4'b0010);
        checks++; if (pos !== 2'd1) begin failures++; $display("FAIL rmid_setup_pos got=%0d exp=1", pos); end
        set_sw(4'b0001);
        tick(4);
        rst_n = 1'b0;
        #1;
        checks++; if (mode !== 2'd0)     begin failures++; $display("FAIL rmid_mode got=%0d exp=0", mode); end
        checks++; if (pos !== 2'd0)      begin failures++; $display("FAIL rmid_pos got=%0d exp=0", pos); end
        checks++; if (blink !== 1'b0)    begin failures++; $display("FAIL rmid_blink got=%0b exp=0", blink); end
        checks++; if (alarm_en !== 1'b0) begin failures++; $display("FAIL rmid_alarm got=%0b exp=0", alarm_en); end
        checks++; if ({inc_hour, inc_min, inc_sec} !== 3'b000)
            begin failures++; $display("FAIL rmid_inc got=%b exp=000", {inc_hour, inc_min, inc_sec}); end
        tick(2);
        rst_n = 1'b1;
        tick(7);
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL held_early got=%0d exp=0", mode); end
        tick(1);
        checks++; if (mode !== 2'd1) begin failures++; $display("FAIL held_press got=%0d exp=1", mode); end
        $display("reset mid-debounce, sw0 held: mode=%0d pos=%0d alarm=%0b", mode, pos, alarm_en);
    endtask

    task automatic test_idle_timeout;
        logic prev_blink;
        int   toggles, first_t, last_t, bad_int, exit_t;
        toggles = 0; first_t = -1; last_t = 0; bad_int = 0; exit_t = -1;
        prev_blink = blink;
        checks++; if (blink !== 1'b0) begin failures++; $display("FAIL idle_start_blink got=%0b exp=0", blink); end
        for (int t = 1; t <= 150 && exit_t < 0; t++) begin
            tick(1);
            if (t == 3) set_sw(4'b0000);
            if (blink !== prev_blink) begin
                toggles++;
                if (first_t < 0) first_t = t;
                else if (t - last_t != 8) bad_int++;
                last_t = t;
            end
            prev_blink = blink;
            if (mode !== 2'd1) exit_t = t;
        end
        checks++; if (first_t !== 8)  begin failures++; $display("FAIL blink_first got=%0d exp=8", first_t); end
        checks++; if (bad_int !== 0)  begin failures++; $display("FAIL blink_period bad=%0d exp=0", bad_int); end
        checks++; if (toggles !== 12) begin failures++; $display("FAIL blink_count got=%0d exp=12", toggles); end
        checks++; if (exit_t !== 100) begin failures++; $display("FAIL idle_exit got=%0d exp=100", exit_t); end
        checks++; if (mode !== 2'd0)  begin failures++; $display("FAIL idle_mode got=%0d exp=0", mode); end
        checks++; if (blink !== 1'b0) begin failures++; $display("FAIL idle_blink got=%0b exp=0", blink); end
        checks++; if (pos !== 2'd0)   begin failures++; $display("FAIL idle_pos got=%0d exp=0", pos); end
        $display("idle timeout: exit_cycle=%0d toggles=%0d mode=%0d blink=%0b", exit_t, toggles, mode, blink);
    endtask

    initial begin
        rst_n = 1'b0;
        set_sw(4'b0000);
        tick(3);
        test_reset;
        test_mode_cycle;
        test_glitch;
        test_clock_ignores;
        test_position_inc;
        test_priority;
        test_reset_mid;
        test_idle_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
